// File: rtl/regfile_mp_pkg.sv
// fusion_rf_pkg: shared constants and types for the multi-port register file.
// Build option: FUSION_RF_BYPASS_EN selects write-through reads (see regfile_rd_port).
package fusion_rf_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_NUM_RD = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, claim and scoreboard signals of the register file.
// slave = register file side, master = decode/writeback side.
// Build option: FUSION_RF_BYPASS_EN (no effect on the interface itself).
interface regfile_mp_if
  import fusion_rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NUM_RD = RF_NUM_RD
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     claim_en;
  logic [ADDR_W-1:0]        claim_addr;
  logic [(2**ADDR_W)-1:0]   busy_vec;

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_valid, rd_busy, busy_vec
  );

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_valid, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// regfile_rd_port: one registered read port (mux, bypass compare, valid/busy flops).
// Build option: FUSION_RF_BYPASS_EN -> a read hitting the same-edge write returns
// wr_data and the post-edge busy bit; otherwise the read sees pre-edge state.
module regfile_rd_port #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [(2**ADDR_W)-1:0] busy,
  input  logic [(2**ADDR_W)-1:0] busy_nxt,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   rd_busy
);

  logic [DATA_W-1:0] data_sel;
  logic              busy_sel;

`ifndef FUSION_RF_BYPASS_EN
  logic bypass_unused;
  assign bypass_unused = ^{wr_en, wr_addr, wr_data, busy_nxt};
`endif

  // Select the value this port captures on the next edge.
  always_comb begin
    data_sel = regs[rd_addr];
    busy_sel = busy[rd_addr];
`ifdef FUSION_RF_BYPASS_EN
    // wr_en is already qualified by the top (R0 writes never arrive here).
    if (wr_en && (wr_addr == rd_addr)) begin
      data_sel = wr_data;
      busy_sel = busy_nxt[rd_addr];
    end
`endif
    if (ZERO_R0 && (rd_addr == '0)) begin
      data_sel = '0;
      busy_sel = 1'b0;
    end
  end

  // Output registers: data/busy hold when idle, valid pulses per accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_busy  <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= data_sel;
        rd_busy <= busy_sel;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with one write port, NUM_RD registered
// read ports, optional hardwired-zero R0 and a per-register pending scoreboard.
// Build option: FUSION_RF_BYPASS_EN enables write-through on same-edge read/write.
module regfile_mp
  import fusion_rf_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned NUM_RD  = RF_NUM_RD,
  parameter bit          ZERO_R0 = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave rf
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busy_nxt;
  logic                     wr_eff;
  logic                     claim_eff;
  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_valid_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  // Qualify write/claim strobes: R0 swallows both when hardwired to zero.
  always_comb begin
    wr_eff    = rf.wr_en    && !(ZERO_R0 && (rf.wr_addr    == '0));
    claim_eff = rf.claim_en && !(ZERO_R0 && (rf.claim_addr == '0));
  end

  // Next scoreboard: a write retires its register, a same-edge claim re-arms it.
  always_comb begin
    busy_nxt = busy;
    if (wr_eff)    busy_nxt[rf.wr_addr]    = 1'b0;
    if (claim_eff) busy_nxt[rf.claim_addr] = 1'b1;
  end

  // Storage and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_eff) regs[rf.wr_addr] <= rf.wr_data;
      busy <= busy_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rf.rd_en[g]),
      .rd_addr  (rf.rd_addr[g*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .busy     (busy),
      .busy_nxt (busy_nxt),
      .wr_en    (wr_eff),
      .wr_addr  (rf.wr_addr),
      .wr_data  (rf.wr_data),
      .rd_data  (rd_data_w[g*DATA_W +: DATA_W]),
      .rd_valid (rd_valid_w[g]),
      .rd_busy  (rd_busy_w[g])
    );
  end

  assign rf.rd_data  = rd_data_w;
  assign rf.rd_valid = rd_valid_w;
  assign rf.rd_busy  = rd_busy_w;
  assign rf.busy_vec = busy;

endmodule
